wb_input_fifo: RTL and testbench

- Wishbone pipelined responder that sits at the other end of the buttons/switches controller.
- Accepts single-beat write transactions carrying the debounced input state and buffers each written word in a FIFO.
- Presents the buffered words to a local consumer (CPU glue or LED logic) over a valid/ready stream.
- Signals back-pressure to the initiator with rty_o when the FIFO is full. Reads and other illegal accesses are answered with err_o.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_input_fifo_if.sv | 24 ++
 rtl/wb_input_fifo_sync_fifo.sv | 42 ++++
 rtl/wb_input_fifo.sv | 79 +++++++
 tb/tb_wb_input_fifo.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types for the Wishbone input FIFO: response encoding and counter widths.
package wb_pkg;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_ACK,
    RESP_RTY,
    RESP_ERR
  } wb_resp_t;

  localparam int DROPS_W = 16;

endpackage

// File: rtl/wb_input_fifo_if.sv
// Wishbone pipelined bus bundle between the buttons/switches controller and the FIFO.
interface wb_input_fifo_if #(
  parameter int DW = 8
);
  logic          cyc_i;
  logic          stb_i;
  logic          we_i;
  logic [DW-1:0] dat_i;
  logic [DW-1:0] dat_o;
  logic          ack_o;
  logic          rty_o;
  logic          err_o;
  logic          stall_o;

  modport master (
    output cyc_i, stb_i, we_i, dat_i,
    input  dat_o, ack_o, rty_o, err_o, stall_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, dat_i,
    output dat_o, ack_o, rty_o, err_o, stall_o
  );
endinterface

// File: rtl/wb_input_fifo_sync_fifo.sv
// Single-clock circular-buffer FIFO; pointers carry a wrap bit above the index.
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);
  localparam int AW = CW - 1;

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [CW-1:0]            wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  // Modular difference of wrap-extended pointers gives 0..DEPTH directly.
  assign count = wptr - rptr;
  assign head  = mem[rptr[AW-1:0]];

  // Storage and pointers; contents are cleared so the head reads 0 after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: rtl/wb_input_fifo.sv
// Wishbone write-only responder that queues input-state words for a local consumer.
module wb_input_fifo
  import wb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  wb_input_fifo_if.slave     wb,
  output logic [DW-1:0]      rd_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [CW-1:0]      count,
  output logic [DW-1:0]      last_word,
  output logic [DROPS_W-1:0] drops
);
  wb_resp_t resp_q, resp_d;
  logic     acc, pop, push, free, full, empty;

  // Stall only while held in reset; otherwise one request per cycle.
  assign wb.stall_o = !rst_ni;
  assign wb.dat_o   = '0;

  assign acc      = wb.cyc_i && wb.stb_i && !wb.stall_o;
  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready;
  // A same-cycle pop frees the slot a full FIFO would otherwise refuse.
  assign free     = !full || pop;
  assign push     = acc && wb.we_i && free;

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (push),
    .push_data (wb.dat_i),
    .pop       (pop),
    .head      (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  // Response slot state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) resp_q <= RESP_NONE;
    else         resp_q <= resp_d;
  end

  // Next response: chosen at acceptance, idle when nothing accepted.
  always_comb begin
    resp_d = RESP_NONE;
    if (acc) begin
      if (!wb.we_i)  resp_d = RESP_ERR;
      else if (free) resp_d = RESP_ACK;
      else           resp_d = RESP_RTY;
    end
  end

  // Decode the registered response into the three exclusive strobes.
  always_comb begin
    wb.ack_o = (resp_q == RESP_ACK);
    wb.rty_o = (resp_q == RESP_RTY);
    wb.err_o = (resp_q == RESP_ERR);
  end

  // Last stored word and saturating refused-write counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_word <= '0;
      drops     <= '0;
    end else begin
      if (push) last_word <= wb.dat_i;
      if (acc && wb.we_i && !free && drops != {DROPS_W{1'b1}})
        drops <= drops + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_input_fifo.sv
// Directed bench for wb_input_fifo: reset, fill/overflow, pop-while-full, err, wrap, async reset.
module tb_wb_input_fifo;
  import wb_pkg::*;

  localparam int DW = 8, DEPTH = 4, CW = 3;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [DW-1:0]      rd_data;
  logic               rd_valid;
  logic               rd_ready;
  logic [CW-1:0]      count;
  logic [DW-1:0]      last_word;
  logic [DROPS_W-1:0] drops;
  int                 passed = 0, total = 0;

  wb_input_fifo_if #(.DW(DW)) wb ();

  wb_input_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wb        (wb),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .count     (count),
    .last_word (last_word),
    .drops     (drops)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic req(input logic cyc, input logic stb, input logic we, input logic [DW-1:0] d);
    wb.cyc_i = cyc; wb.stb_i = stb; wb.we_i = we; wb.dat_i = d;
  endtask

  initial begin
    rst_ni = 1'b0; rd_ready = 1'b0;
    req(0, 0, 0, 8'h00);
    #2;
    chk("rst_stall", wb.stall_o, 1);
    chk("rst_ack", wb.ack_o, 0);
    chk("rst_rty", wb.rty_o, 0);
    chk("rst_err", wb.err_o, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_drops", drops, 0);
    chk("rst_last", last_word, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_dat_o", wb.dat_o, 0);
    tick();
    rst_ni = 1'b1;
    #1;
    chk("stall_after_rst", wb.stall_o, 0);

    // Single write
    tick();
    req(1, 1, 1, 8'h3A);
    tick();
    req(0, 0, 0, 8'h00);
    chk("w1_ack", wb.ack_o, 1);
    chk("w1_rty", wb.rty_o, 0);
    chk("w1_valid", rd_valid, 1);
    chk("w1_data", rd_data, 8'h3A);
    chk("w1_count", count, 1);
    chk("w1_last", last_word, 8'h3A);
    tick();
    chk("w1_ack_1cyc", wb.ack_o, 0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("w1_popped", rd_valid, 0);

    // Fill then overflow
    for (int i = 1; i <= 5; i++) begin
      req(1, 1, 1, DW'(i));
      tick();
      chk("fill_ack", wb.ack_o, (i <= 4) ? 1 : 0);
      chk("fill_rty", wb.rty_o, (i == 5) ? 1 : 0);
    end
    req(0, 0, 0, 8'h00);
    tick();
    chk("fill_count", count, 4);
    chk("fill_drops", drops, 1);
    chk("fill_last", last_word, 8'h04);
    rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", rd_data, i);
      tick();
    end
    rd_ready = 1'b0;
    chk("drain_empty", rd_valid, 0);
    chk("drain_count", count, 0);

    // Full with simultaneous pop
    for (int i = 0; i < 4; i++) begin
      req(1, 1, 1, DW'(8'h21 + i));
      tick();
    end
    chk("refill_count", count, 4);
    req(1, 1, 1, 8'hAA);
    rd_ready = 1'b1;
    tick();
    req(0, 0, 0, 8'h00);
    rd_ready = 1'b0;
    chk("fullpop_ack", wb.ack_o, 1);
    chk("fullpop_rty", wb.rty_o, 0);
    chk("fullpop_count", count, 4);
    chk("fullpop_drops", drops, 1);
    chk("fullpop_last", last_word, 8'hAA);
    rd_ready = 1'b1;
    chk("fp_d0", rd_data, 8'h22); tick();
    chk("fp_d1", rd_data, 8'h23); tick();
    chk("fp_d2", rd_data, 8'h24); tick();
    chk("fp_tail", rd_data, 8'hAA); tick();
    rd_ready = 1'b0;
    chk("fp_empty", rd_valid, 0);

    // Illegal read, then ignored strobe without cycle
    req(1, 1, 0, 8'h5C);
    tick();
    req(0, 1, 1, 8'h77);
    chk("rd_err", wb.err_o, 1);
    chk("rd_ack", wb.ack_o, 0);
    chk("rd_dat_o", wb.dat_o, 0);
    chk("rd_count", count, 0);
    chk("rd_last", last_word, 8'hAA);
    tick();
    req(0, 0, 0, 8'h00);
    chk("nocyc_err", wb.err_o, 0);
    chk("nocyc_ack", wb.ack_o, 0);
    chk("nocyc_count", count, 0);

    // Wrap-around: push/pop pairs across pointer wrap
    for (int i = 0; i < 10; i++) begin
      req(1, 1, 1, DW'(8'h10 + i));
      tick();
      req(0, 0, 0, 8'h00);
      chk("wrap_ack", wb.ack_o, 1);
      chk("wrap_rty", wb.rty_o, 0);
      chk("wrap_count", count, 1);
      rd_ready = 1'b1;
      chk("wrap_data", rd_data, 8'h10 + i);
      tick();
      rd_ready = 1'b0;
      chk("wrap_count0", count, 0);
    end

    // Async reset between two accepted writes
    req(1, 1, 1, 8'h55);
    tick();
    req(1, 1, 1, 8'h66);
    chk("ar_ack_pre", wb.ack_o, 1);
    chk("ar_count_pre", count, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_ack", wb.ack_o, 0);
    chk("ar_rty", wb.rty_o, 0);
    chk("ar_err", wb.err_o, 0);
    chk("ar_valid", rd_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_stall", wb.stall_o, 1);
    req(0, 0, 0, 8'h00);
    tick();
    chk("ar_no_resp", wb.ack_o, 0);
    rst_ni = 1'b1;
    tick();
    req(1, 1, 1, 8'h77);
    tick();
    req(0, 0, 0, 8'h00);
    chk("post_ack", wb.ack_o, 1);
    chk("post_count", count, 1);
    chk("post_last", last_word, 8'h77);
    chk("post_drops", drops, 0);
    chk("post_data", rd_data, 8'h77);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
